bus_dmem_responder: RTL and testbench

Responder end of the CPU data bus: accepts a request carrying `busAddr`, `busWData` and `Byte_Enable` from the CPU datapath, performs a byte-lane-masked write or a full-word read on a local word RAM, and acknowledges with `busReady` after a programmable number of wait states. The block sits on the CPU's data-bus port in place of a zero-latency memory. It un-packs the right-aligned store data the CPU emits, and returns aligned words that the CPU's load-extraction logic slices.

---
 rtl/bus_dmem_responder_pkg.sv | 35 +++
 rtl/bus_dmem_responder_if.sv | 22 ++
 rtl/bus_dmem_responder_dmem_array.sv | 25 ++
 rtl/bus_dmem_responder.sv | 126 ++++++++++++
 tb/tb_bus_dmem_responder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_dmem_responder_pkg.sv
// rtl/bus_dmem_responder_pkg.sv - shared constants and helpers for the data-bus responder
// FSM state codes, legal byte-enable patterns and lane helpers.
package bus_pkg;

  localparam int CNT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] BE_B0 = 4'b0001;
  localparam logic [3:0] BE_B1 = 4'b0010;
  localparam logic [3:0] BE_B2 = 4'b0100;
  localparam logic [3:0] BE_B3 = 4'b1000;
  localparam logic [3:0] BE_H0 = 4'b0011;
  localparam logic [3:0] BE_H1 = 4'b1100;
  localparam logic [3:0] BE_W  = 4'b1111;

  function automatic logic be_legal(input logic [3:0] be);
    case (be)
      BE_B0, BE_B1, BE_B2, BE_B3, BE_H0, BE_H1, BE_W: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Bit shift that moves right-aligned store data up to its lowest enabled lane.
  function automatic logic [4:0] lane_shift(input logic [3:0] be);
    if (be[0])      return 5'd0;
    else if (be[1]) return 5'd8;
    else if (be[2]) return 5'd16;
    else if (be[3]) return 5'd24;
    else            return 5'd0;
  endfunction

endpackage

// File: rtl/bus_dmem_responder_if.sv
// rtl/bus_dmem_responder_if.sv - CPU data-bus request/response bundle
// master = CPU side, slave = responder side.
interface bus_dmem_responder_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [31:0] busWData;
  logic [3:0]  Byte_Enable;
  logic [31:0] busRData;
  logic        busReady;
  logic        busErr;

  modport master (
    output busReq, busWe, busAddr, busWData, Byte_Enable,
    input  busRData, busReady, busErr
  );

  modport slave (
    input  busReq, busWe, busAddr, busWData, Byte_Enable,
    output busRData, busReady, busErr
  );
endinterface

// File: rtl/bus_dmem_responder_dmem_array.sv
// rtl/bus_dmem_responder_dmem_array.sv - byte-lane-masked synchronous word RAM
// Read data is registered every edge; contents are not reset.
module dmem_array #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] idx_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[idx_i];
  end

endmodule

// File: rtl/bus_dmem_responder.sv
// rtl/bus_dmem_responder.sv - data-bus responder with programmable wait states
// Optional BUS_ERR_EN adds region, byte-enable and alignment fault reporting.
module bus_dmem_responder
  import bus_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_dmem_responder_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       be_q;
  logic             we_q, err_q;

  logic             idle_accept, commit;
  logic [31:0]      cur_addr, cur_wdata, ram_rdata, rdata_out;
  logic [3:0]       cur_be, ram_be;
  logic             cur_we, cur_err, ram_we;

  // In IDLE the live bus fields feed the datapath so a zero-wait access commits on its accept edge.
  assign idle_accept = (state_q == S_IDLE) && bus.busReq;
  assign cur_addr    = (state_q == S_IDLE) ? bus.busAddr     : addr_q;
  assign cur_wdata   = (state_q == S_IDLE) ? bus.busWData    : wdata_q;
  assign cur_be      = (state_q == S_IDLE) ? bus.Byte_Enable : be_q;
  assign cur_we      = (state_q == S_IDLE) ? bus.busWe       : we_q;

`ifdef BUS_ERR_EN
  logic [31:0] cur_off;
  logic        range_ok, align_ok;

  assign cur_off  = cur_addr - BASE_ADDR;
  assign range_ok = (cur_addr >= BASE_ADDR) && ((cur_off >> (ADDR_WIDTH + 2)) == 32'd0);

  always_comb begin
    align_ok = 1'b0;
    case (cur_be)
      BE_B0, BE_H0: align_ok = (cur_addr[1:0] == 2'd0);
      BE_B1:        align_ok = (cur_addr[1:0] == 2'd1);
      BE_B2, BE_H1: align_ok = (cur_addr[1:0] == 2'd2);
      BE_B3:        align_ok = (cur_addr[1:0] == 2'd3);
      BE_W:         align_ok = 1'b1;
      default:      align_ok = 1'b0;
    endcase
  end

  assign cur_err = !(range_ok && align_ok);
`else
  logic unused_ok;
  assign cur_err   = 1'b0;
  assign unused_ok = ^{BASE_ADDR, cur_addr[31:ADDR_WIDTH+2], cur_addr[1:0]};
`endif

  assign commit = (idle_accept && (WAIT_STATES == 0)) ||
                  ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)));

  assign ram_we = commit && cur_we && !cur_err;
  assign ram_be = be_legal(cur_be) ? cur_be : 4'b0000;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_dmem_array (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .idx_i   (cur_addr[ADDR_WIDTH+1:2]),
    .wdata_i (cur_wdata << lane_shift(cur_be)),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.busReq) begin
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (commit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Writes and idle cycles keep presenting the previously returned word.
  assign rdata_out = (state_q != S_RESP) ? rdata_q :
                     err_q               ? 32'd0   :
                     we_q                ? rdata_q : ram_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_out;
      if (idle_accept) begin
        addr_q  <= bus.busAddr;
        wdata_q <= bus.busWData;
        be_q    <= bus.Byte_Enable;
        we_q    <= bus.busWe;
        err_q   <= cur_err;
      end
    end
  end

  assign bus.busReady = (state_q == S_RESP);
  assign bus.busErr   = (state_q == S_RESP) && err_q;
  assign bus.busRData = rdata_out;

endmodule

// File: tb/tb_bus_dmem_responder.sv
// tb/tb_bus_dmem_responder.sv - scoreboard bench for bus_dmem_responder
// Three instances (0, 1 and 3 wait states) checked against a word-array model.
module tb_bus_dmem_responder;
  import bus_pkg::*;

  localparam logic [31:0] BASE = 32'h1000_0000;

  typedef struct {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_dmem_responder_if b0 ();
  bus_dmem_responder_if b1 ();
  bus_dmem_responder_if b3 ();

  bus_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
  bus_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
  bus_dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(3), .BASE_ADDR(BASE)) u_dut3 (.clk(clk), .reset(reset), .bus(b3));

  exp_t        q0[$], q1[$], q3[$];
  logic [31:0] mem   [4][256];
  bit          known [4][256];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic bit be_ok(input logic [3:0] be);
    return be == 4'b0001 || be == 4'b0010 || be == 4'b0100 || be == 4'b1000 ||
           be == 4'b0011 || be == 4'b1100 || be == 4'b1111;
  endfunction

  function automatic int lowest_lane(input logic [3:0] be);
    for (int i = 0; i < 4; i++) if (be[i]) return i;
    return 0;
  endfunction

  function automatic bit model_err(input logic [31:0] a, input logic [3:0] be);
`ifdef BUS_ERR_EN
    int lo;
    if (!be_ok(be)) return 1'b1;
    if (a < BASE || a > BASE + 32'd1023) return 1'b1;
    if (be == 4'b1111) return 1'b0;
    lo = lowest_lane(be);
    return a[1:0] != lo[1:0];
`else
    return 1'b0 & a[0] & be[0];
`endif
  endfunction

  // Enabled lanes take consecutive bytes of the right-aligned store data.
  function automatic void model(input int s, input logic we, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] be, output exp_t e);
    int idx;
    int k;
    idx      = int'(a[9:2]);
    k        = 0;
    e.err    = model_err(a, be);
    e.rdata  = 32'd0;
    e.chk_rd = 1'b0;
    if (e.err) begin
      e.chk_rd = 1'b1;
    end else if (!we) begin
      e.chk_rd = known[s][idx];
      e.rdata  = mem[s][idx];
    end else if (be_ok(be)) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem[s][idx][8*i +: 8] = w[8*k +: 8];
          k++;
        end
      end
      if (be == 4'b1111) known[s][idx] = 1'b1;
    end
  endfunction

  function automatic void check(input int s, input exp_t e, input logic [31:0] rd, input logic er);
    vectors++;
    if (er !== e.err) begin
      miscompares++;
      $display("FAIL busErr dut%0d: got %0b want %0b", s, er, e.err);
    end
    if (e.chk_rd) begin
      vectors++;
      if (rd !== e.rdata) begin
        miscompares++;
        $display("FAIL busRData dut%0d: got %08h want %08h", s, rd, e.rdata);
      end
    end
  endfunction

  function automatic void unexpected(input int s);
    vectors++;
    miscompares++;
    $display("FAIL unexpected_ready dut%0d: got busReady=1 want no response", s);
  endfunction

  always @(negedge clk) if (b0.busReady === 1'b1) begin
    if (q0.size() == 0) unexpected(0); else check(0, q0.pop_front(), b0.busRData, b0.busErr);
  end
  always @(negedge clk) if (b1.busReady === 1'b1) begin
    if (q1.size() == 0) unexpected(1); else check(1, q1.pop_front(), b1.busRData, b1.busErr);
  end
  always @(negedge clk) if (b3.busReady === 1'b1) begin
    if (q3.size() == 0) unexpected(3); else check(3, q3.pop_front(), b3.busRData, b3.busErr);
  end

  task automatic chk_val(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %08h want %08h", name, got, want);
    end
  endtask

  task automatic drive(input int s, input logic rq, input logic we, input logic [31:0] a,
                       input logic [31:0] w, input logic [3:0] be);
    case (s)
      0: begin b0.busReq = rq; b0.busWe = we; b0.busAddr = a; b0.busWData = w; b0.Byte_Enable = be; end
      1: begin b1.busReq = rq; b1.busWe = we; b1.busAddr = a; b1.busWData = w; b1.Byte_Enable = be; end
      default: begin b3.busReq = rq; b3.busWe = we; b3.busAddr = a; b3.busWData = w; b3.Byte_Enable = be; end
    endcase
  endtask

  function automatic logic rdy(input int s);
    case (s)
      0: return b0.busReady;
      1: return b1.busReady;
      default: return b3.busReady;
    endcase
  endfunction

  // Issues one access from an IDLE cycle and checks busReady arrives WS+1 edges later.
  task automatic access(input int s, input logic we, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] be);
    exp_t e;
    int   n;
    logic seen;
    model(s, we, a, w, be, e);
    case (s)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q3.push_back(e);
    endcase
    drive(s, 1'b1, we, a, w, be);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      seen = rdy(s);
    end
    vectors++;
    if (!seen || n != s + 1) begin
      miscompares++;
      $display("FAIL latency dut%0d: got %0d edges (ready=%0b) want %0d", s, n, seen, s + 1);
    end
    drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
    @(posedge clk); #1;
  endtask

  task automatic random_access(input int s, input int nwords);
    logic [3:0]  tbl [9];
    logic [3:0]  be;
    logic [31:0] a;
    int          lo;
    tbl = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0101, 4'b0000};
    be  = tbl[$urandom_range(0, 8)];
    lo  = (be == 4'b1111) ? 0 : lowest_lane(be);
    a   = BASE + 32'($urandom_range(0, nwords - 1)) * 32'd4 + 32'(lo);
    if ($urandom_range(0, 15) == 0) a = a ^ 32'h4000_0000;
    access(s, 1'($urandom_range(0, 1)), a, $urandom, be);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
    repeat (3) @(posedge clk);
    #1;
    chk_val("reset_ready0", 32'(b0.busReady), 32'd0);
    chk_val("reset_ready1", 32'(b1.busReady), 32'd0);
    chk_val("reset_ready3", 32'(b3.busReady), 32'd0);
    chk_val("reset_err1", 32'(b1.busErr), 32'd0);
    chk_val("reset_rdata0", b0.busRData, 32'd0);
    chk_val("reset_rdata1", b1.busRData, 32'd0);
    chk_val("reset_rdata3", b3.busRData, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    access(1, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF, BE_W);
    access(1, 1'b0, BASE + 32'h10, 32'd0, BE_W);
    access(1, 1'b1, BASE, 32'd0, BE_W);
    access(1, 1'b1, BASE + 32'd0, 32'h0000_0011, BE_B0);
    access(1, 1'b1, BASE + 32'd1, 32'h0000_0022, BE_B1);
    access(1, 1'b1, BASE + 32'd2, 32'h0000_0033, BE_B2);
    access(1, 1'b1, BASE + 32'd3, 32'h0000_0044, BE_B3);
    access(1, 1'b0, BASE, 32'd0, BE_W);
    access(1, 1'b1, BASE + 32'h8, 32'h1234_5678, BE_W);
    access(1, 1'b1, BASE + 32'hA, 32'h0000_BEEF, BE_H1);
    access(1, 1'b0, BASE + 32'h8, 32'd0, BE_W);
    access(1, 1'b1, 32'h2000_0000, 32'hCAFE_F00D, BE_W);
    access(1, 1'b1, BASE + 32'h11, 32'h0000_5555, BE_H0);
    access(1, 1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0101);
    access(1, 1'b0, BASE, 32'd0, BE_W);
    access(1, 1'b0, BASE + 32'h10, 32'd0, BE_W);

    for (int i = 0; i < 32; i++) access(1, 1'b1, BASE + 32'(i) * 32'd4, $urandom, BE_W);
    for (int i = 0; i < 120; i++) random_access(1, 32);

    for (int i = 0; i < 8; i++) access(0, 1'b1, BASE + 32'(i) * 32'd4, $urandom, BE_W);
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = BASE + 32'($urandom_range(0, 7)) * 32'd4;
      access(0, 1'b1, a, $urandom, BE_W);
      access(0, 1'b0, a, 32'd0, BE_W);
      random_access(0, 8);
    end

    access(3, 1'b1, BASE + 32'h14, 32'h1234_5678, BE_W);
    drive(3, 1'b1, 1'b1, BASE + 32'h14, 32'hFFFF_FFFF, BE_W);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk_val("abort_ready3", 32'(b3.busReady), 32'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    chk_val("abort_ready3_hold", 32'(b3.busReady), 32'd0);
    chk_val("abort_rdata3", b3.busRData, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    access(3, 1'b0, BASE + 32'h14, 32'd0, BE_W);
    access(3, 1'b1, BASE + 32'h18, 32'hA5A5_0F0F, BE_W);
    access(3, 1'b0, BASE + 32'h18, 32'd0, BE_W);

    repeat (3) @(posedge clk);
    #1;
    chk_val("queues_drained", 32'(q0.size() + q1.size() + q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
